// File: rtl/quick_start_timer_ctrl.sv
// Microwave cook-time register and cooking FSM with debounced start/stop buttons and quick-start add.
// Press acts DEBOUNCE_CYCLES+3 clocks after first sampled high; BCD outputs trail the time register by one clock.
module quick_start_timer_ctrl #(
  parameter int ADD_SECONDS     = 30,
  parameter int MAX_MINUTES     = 99,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter bit ADD_ON_START    = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start_button,
  input  logic       stop_button,
  input  logic       door_open,
  input  logic       tick_1hz,
  input  logic       load_en,
  input  logic [3:0] load_first_sec,
  input  logic [3:0] load_second_sec,
  input  logic [3:0] load_first_min,
  input  logic [3:0] load_second_min,
  output logic [3:0] first_sec,
  output logic [3:0] second_sec,
  output logic [3:0] first_min,
  output logic [3:0] second_min,
  output logic       microwave_power_on,
  output logic [1:0] state,
  output logic       done_pulse
);

  localparam int MAX_T = MAX_MINUTES * 60 + 59;
  localparam int TW    = $clog2(MAX_MINUTES * 60 + 60);
  localparam int CW    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [15:0] ADD16 = 16'(ADD_SECONDS);
  localparam logic [15:0] MAX16 = 16'(MAX_T);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUNNING = 2'd1,
    S_PAUSED  = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  function automatic logic [TW-1:0] sat(input logic [15:0] x);
    return (x > MAX16) ? TW'(MAX16) : TW'(x);
  endfunction

  // Bit 0 is the start button, bit 1 is stop.
  logic [1:0]    w_raw;
  logic [1:0]    r_sync1, r_sync2, r_deb, r_deb_d, r_evt;
  logic [CW-1:0] r_cnt [2];

  assign w_raw = {stop_button, start_button};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_deb    <= '0;
      r_deb_d  <= '0;
      r_evt    <= '0;
      r_cnt[0] <= '0;
      r_cnt[1] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_deb_d <= r_deb;
      r_evt   <= r_deb & ~r_deb_d;
      for (int b = 0; b < 2; b++) begin
        if (r_sync2[b] == r_deb[b]) begin
          r_cnt[b] <= '0;
        end else if (r_cnt[b] == CW'(DEBOUNCE_CYCLES - 1)) begin
          r_deb[b] <= ~r_deb[b];
          r_cnt[b] <= '0;
        end else begin
          r_cnt[b] <= r_cnt[b] + CW'(1);
        end
      end
    end
  end

  state_t        r_state, w_state_nxt;
  logic [TW-1:0] r_time, w_time_nxt, w_resume;
  logic          r_power, r_done, w_done_nxt;
  logic [15:0]   r_bcd, w_bcd;
  logic [15:0]   w_t16, w_tdec16, w_load16, w_min16, w_sec16;
  logic          w_load_ok, w_start_ok, w_stop;

  assign w_t16     = 16'(r_time);
  assign w_tdec16  = tick_1hz ? (w_t16 - 16'd1) : w_t16;
  assign w_load16  = 16'(load_second_min) * 16'd600 + 16'(load_first_min) * 16'd60
                   + 16'(load_second_sec) * 16'd10 + 16'(load_first_sec);
  assign w_load_ok = (load_first_sec <= 4'd9) && (load_second_sec <= 4'd5) &&
                     (load_first_min <= 4'd9) && (load_second_min <= 4'd9);
  assign w_stop     = r_evt[1];
  // Stop and an open door both swallow a start event outright.
  assign w_start_ok = r_evt[0] & ~door_open & ~r_evt[1];
  assign w_resume   = ADD_ON_START ? sat(w_t16 + ADD16) : r_time;

  always_comb begin
    w_state_nxt = r_state;
    w_time_nxt  = r_time;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_stop) begin
          if (w_start_ok) begin
            w_time_nxt  = (r_time == '0) ? TW'(ADD16) : w_resume;
            w_state_nxt = S_RUNNING;
          end else if (load_en && w_load_ok) begin
            w_time_nxt = sat(w_load16);
          end
        end
      end
      S_RUNNING: begin
        if (w_stop || door_open) begin
          w_state_nxt = S_PAUSED;
        end else if (w_start_ok) begin
          w_time_nxt = sat(w_tdec16 + ADD16);
        end else if (tick_1hz && (r_time != '0)) begin
          w_time_nxt = r_time - TW'(1);
          if (r_time == TW'(1)) begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      S_PAUSED: begin
        if (w_stop) begin
          w_state_nxt = S_IDLE;
          w_time_nxt  = '0;
        end else if (w_start_ok) begin
          w_time_nxt  = w_resume;
          w_state_nxt = S_RUNNING;
        end
      end
      S_DONE: begin
        if (w_stop) begin
          w_state_nxt = S_IDLE;
        end else if (w_start_ok) begin
          w_time_nxt  = TW'(ADD16);
          w_state_nxt = S_RUNNING;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_min16 = w_t16 / 16'd60;
  assign w_sec16 = w_t16 - w_min16 * 16'd60;
  assign w_bcd   = {4'(w_min16 / 16'd10), 4'(w_min16 % 16'd10),
                    4'(w_sec16 / 16'd10), 4'(w_sec16 % 16'd10)};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_time  <= '0;
      r_power <= 1'b0;
      r_done  <= 1'b0;
      r_bcd   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_time  <= w_time_nxt;
      r_power <= (w_state_nxt == S_RUNNING);
      r_done  <= w_done_nxt;
      r_bcd   <= w_bcd;
    end
  end

  assign second_min         = r_bcd[15:12];
  assign first_min          = r_bcd[11:8];
  assign second_sec         = r_bcd[7:4];
  assign first_sec          = r_bcd[3:0];
  assign microwave_power_on = r_power;
  assign state              = r_state;
  assign done_pulse         = r_done;

endmodule
